// File: rtl/gate_chk_pkg.sv
// Shared types, y bit map and truth-table function for the basic-gates self-test checker.
package gate_chk_pkg;

    localparam int unsigned Y_W   = 7;
    localparam int unsigned CNT_W = 8;

    localparam int unsigned Y_AND  = 0;
    localparam int unsigned Y_OR   = 1;
    localparam int unsigned Y_NAND = 2;
    localparam int unsigned Y_NOR  = 3;
    localparam int unsigned Y_XOR  = 4;
    localparam int unsigned Y_XNOR = 5;
    localparam int unsigned Y_NOT  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [Y_W-1:0] gate_expected(input logic a, input logic b);
        logic [Y_W-1:0] e;
        e         = '0;
        e[Y_AND]  = a & b;
        e[Y_OR]   = a | b;
        e[Y_NAND] = ~(a & b);
        e[Y_NOR]  = ~(a | b);
        e[Y_XOR]  = a ^ b;
        e[Y_XNOR] = ~(a ^ b);
        e[Y_NOT]  = ~a;
        return e;
    endfunction

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Settle down-counter: load on DRIVE entry, count while enabled, terminal count at zero.
module gate_chk_settle_cnt
    import gate_chk_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(LOAD_VAL);
        end else if (i_en && !o_tc_c) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Self-test sequencer/response checker for the two-input basic-gates block.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [Y_W-1:0] y,
    output logic           a,
    output logic           b,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2:0]     err_count,
    output logic [Y_W-1:0] mismatch,
    output logic [1:0]     first_fail_vec,
    output logic           first_fail_valid
);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    if ((SETTLE_CYCLES == 0) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("gate_response_checker: SETTLE_CYCLES must be 1..255");
    end

    state_t         r_state, w_state_nxt;
    logic           r_a, r_b, r_busy, r_done, r_pass, r_ff_valid;
    logic [2:0]     r_err;
    logic [Y_W-1:0] r_mismatch;
    logic [1:0]     r_ff_vec;

    logic           w_a_nxt, w_b_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt, w_ff_valid_nxt;
    logic [2:0]     w_err_nxt;
    logic [Y_W-1:0] w_mismatch_nxt, w_diff;
    logic [1:0]     w_ff_vec_nxt, w_vec_inc;
    logic           w_fail, w_load, w_tc;

    gate_chk_settle_cnt #(
        .LOAD_VAL (SETTLE_CYCLES - 1)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (r_state == DRIVE),
        .o_tc_c (w_tc)
    );

    assign w_diff    = y ^ gate_expected(r_a, r_b);
    assign w_fail    = |w_diff;
    assign w_vec_inc = {r_a, r_b} + 2'd1;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_mismatch <= '0;
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err      <= w_err_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_ff_vec   <= w_ff_vec_nxt;
            r_ff_valid <= w_ff_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        w_err_nxt      = r_err;
        w_mismatch_nxt = r_mismatch;
        w_ff_vec_nxt   = r_ff_vec;
        w_ff_valid_nxt = r_ff_valid;
        w_load         = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt    = DRIVE;
                    w_a_nxt        = 1'b0;
                    w_b_nxt        = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_err_nxt      = '0;
                    w_mismatch_nxt = '0;
                    w_ff_vec_nxt   = '0;
                    w_ff_valid_nxt = 1'b0;
                    w_load         = 1'b1;
                end
            end
            DRIVE: begin
                if (w_tc) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_mismatch_nxt = r_mismatch | w_diff;
                if (w_fail) begin
                    w_err_nxt = r_err + 3'd1;
                    if (!r_ff_valid) begin
                        w_ff_valid_nxt = 1'b1;
                        w_ff_vec_nxt   = {r_a, r_b};
                    end
                end
                // Last vector, or stop-on-fail: a/b stay on the vector just checked
                if (({r_a, r_b} == 2'd3) || (STOP_ON_FAIL && w_fail)) begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_nxt == '0);
                end else begin
                    w_state_nxt        = DRIVE;
                    {w_a_nxt, w_b_nxt} = w_vec_inc;
                    w_load             = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign a                = r_a;
    assign b                = r_b;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign mismatch         = r_mismatch;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: table-driven fault models, random y tables, corner sequences.
module tb_gate_response_checker;

    localparam int unsigned S       = 4;
    localparam int unsigned VEC_CYC = S + 1;
    localparam int          BUDGET  = 200;

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // Per-gate truth tables, bit v = output for {a,b}=v; order AND,OR,NAND,NOR,XOR,XNOR,NOT a
    localparam logic [3:0] TT [7] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011};

    typedef struct {
        string           name;
        logic [3:0][6:0] flip;
        int              exp_err;
        int              exp_err_stop;
        int              exp_nvec_stop;
        logic [6:0]      exp_mm;
        logic [1:0]      exp_ffv;
        bit              exp_val;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] y;
    logic       a, b, busy, done, pass, ffval;
    logic [2:0] err_count;
    logic [6:0] mismatch;
    logic [1:0] ffv;

    logic [6:0] g_ytab [4];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] abq [$];

    always #5 clk = ~clk;

    assign y = g_ytab[{a, b}];

    gate_response_checker #(.SETTLE_CYCLES(S)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .y                (y),
        .a                (a),
        .b                (b),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .mismatch         (mismatch),
        .first_fail_vec   (ffv),
        .first_fail_valid (ffval)
    );

    function automatic logic [6:0] truth(input int v);
        logic [6:0] r;
        logic [1:0] idx;
        idx = v[1:0];
        for (int g = 0; g < 7; g++) r[g] = TT[g][idx];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load_flip(input logic [3:0][6:0] flip);
        for (int v = 0; v < 4; v++) g_ytab[v] = truth(v) ^ flip[v];
    endtask

    task automatic model_run(output int err, output logic [6:0] mm, output logic [1:0] fvec,
                             output bit fval, output int nvec);
        logic [6:0] d;
        err = 0; mm = '0; fvec = '0; fval = 1'b0; nvec = 0;
        for (int v = 0; v < 4; v++) begin
            nvec = v + 1;
            d = g_ytab[v] ^ truth(v);
            mm |= d;
            if (d != '0) begin
                err++;
                if (!fval) begin
                    fval = 1'b1;
                    fvec = 2'(v);
                end
                if (STOP) break;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Counts cycles from the accepting edge until done, recording a/b each cycle
    task automatic wait_done(input int extra_start_at, output int cycles);
        cycles = 0;
        abq.delete();
        while (!done && cycles < BUDGET) begin
            abq.push_back({a, b});
            if (cycles == extra_start_at) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            cycles++;
        end
    endtask

    task automatic run_and_check(input string tag, input int exp_err, input logic [6:0] exp_mm,
                                 input logic [1:0] exp_ffv, input bit exp_val, input int exp_nvec,
                                 input int extra_start_at);
        int cycles;
        bit ok;
        pulse_start();
        check({tag, "_start"}, 32'({busy, done, a, b, err_count, mismatch, ffval}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0}));
        wait_done(extra_start_at, cycles);
        check({tag, "_latency"}, 32'(cycles), 32'(exp_nvec * int'(VEC_CYC)));
        ok = 1'b1;
        foreach (abq[k]) if (abq[k] !== 2'(k / int'(VEC_CYC))) ok = 1'b0;
        check({tag, "_ab_seq"}, 32'(ok), 32'd1);
        check({tag, "_err"}, 32'(err_count), 32'(exp_err));
        check({tag, "_mismatch"}, 32'(mismatch), 32'(exp_mm));
        check({tag, "_ffvec"}, 32'({ffval, ffv}), 32'({exp_val, exp_ffv}));
        check({tag, "_pass"}, 32'({pass, busy}), 32'({exp_err == 0, 1'b0}));
        check({tag, "_final_ab"}, 32'({a, b}), 32'(exp_nvec - 1));
        repeat (3) @(posedge clk);
        #1 check({tag, "_done_hold"}, 32'({done, err_count}), 32'({1'b1, 3'(exp_err)}));
    endtask

    initial begin
        vec_t tbl [5];
        int   err, nvec, cycles;
        logic [6:0] mm;
        logic [1:0] fvec;
        bit   fval;

        tbl[0] = '{"xor_stuck0", {7'h00, 7'h10, 7'h10, 7'h00}, 2, 1, 2, 7'h10, 2'b01, 1'b1};
        tbl[1] = '{"correct",    {7'h00, 7'h00, 7'h00, 7'h00}, 0, 0, 4, 7'h00, 2'b00, 1'b0};
        tbl[2] = '{"not_inv",    {7'h40, 7'h40, 7'h40, 7'h40}, 4, 1, 1, 7'h40, 2'b00, 1'b1};
        tbl[3] = '{"correct2",   {7'h00, 7'h00, 7'h00, 7'h00}, 0, 0, 4, 7'h00, 2'b00, 1'b0};
        tbl[4] = '{"and_stuck1", {7'h00, 7'h01, 7'h01, 7'h01}, 3, 1, 1, 7'h01, 2'b00, 1'b1};

        load_flip('0);
        repeat (2) @(posedge clk);
        #1 check("reset_vals", 32'({a, b, busy, done, pass, err_count, mismatch, ffv, ffval}), 32'd0);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_quiet", 32'({busy, done}), 32'd0);

        // Table rows; the second row also gets an ignored start during DRIVE of vector 2
        for (int i = 0; i < 5; i++) begin
            load_flip(tbl[i].flip);
            run_and_check(tbl[i].name, STOP ? tbl[i].exp_err_stop : tbl[i].exp_err, tbl[i].exp_mm,
                          tbl[i].exp_ffv, tbl[i].exp_val, STOP ? tbl[i].exp_nvec_stop : 4,
                          (i == 1) ? 2 * int'(VEC_CYC) + 1 : -1);
        end

        // Random y tables against the reference model
        for (int r = 0; r < 10; r++) begin
            for (int v = 0; v < 4; v++)
                g_ytab[v] = truth(v) ^ (($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00);
            model_run(err, mm, fvec, fval, nvec);
            run_and_check($sformatf("rand%0d", r), err, mm, fvec, fval, nvec, -1);
        end

        // Reset asserted during CHECK of vector 1
        load_flip(tbl[0].flip);
        pulse_start();
        repeat (2 * VEC_CYC - 1) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_abort", 32'({a, b, busy, done, pass, err_count, mismatch, ffv, ffval}), 32'd0);
        #3 rst_n = 1'b1;
        load_flip('0);
        run_and_check("after_rst", 0, 7'h00, 2'b00, 1'b0, 4, -1);

        // start high on the edge entering DONE is ignored, taken one cycle later
        pulse_start();
        repeat (4 * VEC_CYC - 1) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 check("start_on_done_edge", 32'({done, busy, pass}), 32'({1'b1, 1'b0, 1'b1}));
        @(posedge clk);
        #1 start = 1'b0;
        check("start_after_done", 32'({done, busy, a, b}), 32'({1'b0, 1'b1, 2'b00}));
        wait_done(-1, cycles);
        check("restart_latency", 32'(cycles), 32'(4 * VEC_CYC));
        check("restart_pass", 32'({pass, err_count}), 32'({1'b1, 3'd0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
